// File: rtl/tone_pkg.sv
// Shared constants, FSM state type and the elaboration-time half-period helper
// for the note tone generator.
package tone_pkg;

    localparam logic [5:0] REST_CODE = 6'd63;
    localparam logic [5:0] MAX_TONE  = 6'd47;

    typedef enum logic [1:0] {
        ST_SILENT,
        ST_HIGH,
        ST_LOW
    } tone_state_t;

    // Top-octave frequencies (codes 36..47) in millihertz.
    localparam longint unsigned FREQ_MHZ [12] = '{
        64'd880000,  64'd932328,  64'd987767,  64'd1046502,
        64'd1108731, 64'd1174659, 64'd1244508, 64'd1318510,
        64'd1396913, 64'd1479978, 64'd1567982, 64'd1661219
    };

    // Lower octaves halve the frequency, so the numerator is scaled up instead
    // of the table value being divided down (keeps the floor exact).
    function automatic longint unsigned half_period(input int unsigned code,
                                                    input longint unsigned clk_hz);
        int unsigned oct;
        logic [3:0]  idx;
        if (code > 32'(MAX_TONE)) return 64'd0;
        oct = code / 12;
        idx = 4'(code % 12);
        return ((clk_hz * 64'd1000) << (3 - oct)) / (64'd2 * FREQ_MHZ[idx]);
    endfunction

endpackage

// File: rtl/note_sync.sv
// Two-flop synchroniser for the asynchronous note code followed by a
// stability filter that strobes once per value held STABLE_CYC cycles.
module note_sync
    import tone_pkg::*;
#(
    parameter int STABLE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] note,
    output logic [5:0] code,
    output logic       accept
);

    localparam int CW = $clog2(STABLE_CYC + 2);

    logic [5:0]    sync1, sync2, stab_val;
    logic [CW-1:0] stab_cnt, run, run_sat;

    // run = cycles the synchronised value has held, including this one
    always_comb begin
        run     = (sync2 == stab_val) ? stab_cnt + 1'b1 : CW'(1);
        run_sat = (run > CW'(STABLE_CYC)) ? CW'(STABLE_CYC) : run;
    end

    assign accept = (run == CW'(STABLE_CYC));
    assign code   = sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= REST_CODE;
            sync2    <= REST_CODE;
            stab_val <= REST_CODE;
            stab_cnt <= CW'(STABLE_CYC);
        end else begin
            sync1    <= note;
            sync2    <= sync1;
            stab_val <= sync2;
            stab_cnt <= run_sat;
        end
    end

endmodule

// File: rtl/note_tone_gen.sv
// Note-code to square-wave buzzer driver. Optional TONEGEN_VOL_EN adds a vol
// input that shortens the high part of each period (duty-cycle volume).
module note_tone_gen
    import tone_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int CNT_W      = 20,
    parameter int STABLE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] note,
`ifdef TONEGEN_VOL_EN
    input  logic [2:0] vol,
`endif
    output logic       buzzer,
    output logic [5:0] cur_note,
    output logic       sounding,
    output logic       note_chg
);

    logic [5:0]       acc_code, acc_tone, pend_q, pend_d, cur_q, cur_d;
    logic             acc, chg_q, chg_d, buzz_q, buzz_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, half_cur;
    logic [CNT_W-1:0] half_tbl [48];
    tone_state_t      state_q, state_d;

    for (genvar g = 0; g < 48; g++) begin : g_half
        localparam longint unsigned HP = half_period(32'(g), 64'(CLK_HZ));
        assign half_tbl[g] = CNT_W'(HP);
    end

    note_sync #(.STABLE_CYC(STABLE_CYC)) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .note   (note),
        .code   (acc_code),
        .accept (acc)
    );

    assign acc_tone = (acc_code > MAX_TONE) ? REST_CODE : acc_code;
    assign half_cur = (cur_q <= MAX_TONE) ? half_tbl[cur_q] : '0;

    // pending == cur_note means nothing is waiting; re-accepting the sounding
    // note simply cancels any earlier pending change.
    always_comb begin
        pend_d  = acc ? acc_tone : pend_q;
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        chg_d   = 1'b0;
        case (state_q)
            ST_SILENT: begin
                if (pend_q != REST_CODE) begin
                    state_d = ST_HIGH;
                    cur_d   = pend_q;
                    cnt_d   = '0;
                    chg_d   = 1'b1;
                end
            end
            default: begin
                if (cnt_q != half_cur - 1'b1) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d   = '0;
                    state_d = (state_q == ST_HIGH) ? ST_LOW : ST_HIGH;
                    if (pend_q != cur_q && (pend_q == REST_CODE || state_q == ST_LOW)) begin
                        cur_d   = pend_q;
                        chg_d   = 1'b1;
                        state_d = (pend_q == REST_CODE) ? ST_SILENT : ST_HIGH;
                    end
                end
            end
        endcase
    end

`ifdef TONEGEN_VOL_EN
    logic [CNT_W-1:0] thr_q, thr_d, half_nxt;

    // Threshold latched at each period start so vol changes never cut a pulse.
    always_comb begin
        half_nxt = (cur_d <= MAX_TONE) ? half_tbl[cur_d] : '0;
        thr_d    = thr_q;
        if (state_d == ST_HIGH && state_q != ST_HIGH)
            thr_d = CNT_W'(((CNT_W+3)'(half_nxt) * (CNT_W+3)'(vol)
                           + (CNT_W+3)'(half_nxt)) >> 3);
        buzz_d   = (state_d == ST_HIGH) && (cnt_d < thr_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) thr_q <= '0;
        else        thr_q <= thr_d;
    end
`else
    assign buzz_d = (state_d == ST_HIGH);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SILENT;
            cur_q   <= REST_CODE;
            pend_q  <= REST_CODE;
            cnt_q   <= '0;
            chg_q   <= 1'b0;
            buzz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            chg_q   <= chg_d;
            buzz_q  <= buzz_d;
        end
    end

    assign buzzer   = buzz_q;
    assign cur_note = cur_q;
    assign sounding = (cur_q != REST_CODE);
    assign note_chg = chg_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Randomised and directed bench for note_tone_gen against a period-level
// behavioural model (frequencies computed with real arithmetic).
`timescale 1ns/1ps
module tb_note_tone_gen;

    localparam int CLK_HZ     = 1_000_000;
    localparam int CNT_W      = 20;
    localparam int STABLE_CYC = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] note  = 6'd63;
    logic       buzzer, sounding, note_chg;
    logic [5:0] cur_note;
`ifdef TONEGEN_VOL_EN
    logic [2:0] vol = 3'd7;
`endif

    int n_vec = 0;
    int n_err = 0;

    note_tone_gen #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W), .STABLE_CYC(STABLE_CYC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .note     (note),
`ifdef TONEGEN_VOL_EN
        .vol      (vol),
`endif
        .buzzer   (buzzer),
        .cur_note (cur_note),
        .sounding (sounding),
        .note_chg (note_chg)
    );

    always #5 clk = ~clk;

    function automatic int model_half(input int code);
        real f;
        f = 440.0 * $pow(2.0, (code - 24) / 12.0);
        return int'($floor(real'(CLK_HZ) / (2.0 * f)));
    endfunction

    // ---------------- behavioural model ----------------
    int         m_cur, m_pend, m_el, m_thr, m_h;
    bit         m_chg, m_acc;
    logic [5:0] m_s1;
    logic [5:0] m_win [0:STABLE_CYC];
    logic [5:0] s_note;
    int         s_vol;
    int         old_pend;
    logic [8:0] exp_v, act_v;

    function automatic int as_code(input logic [5:0] c);
        return (c > 6'd47) ? 63 : int'(c);
    endfunction

    task automatic model_reset();
        m_cur = 63; m_pend = 63; m_el = 0; m_thr = 0; m_chg = 1'b0; m_s1 = 6'd63;
        for (int i = 0; i <= STABLE_CYC; i++) m_win[i] = 6'd63;
    endtask

    task automatic start_period(input int v);
        m_el = 0;
`ifdef TONEGEN_VOL_EN
        m_thr = (model_half(m_cur) * (v + 1)) / 8;
`else
        m_thr = model_half(m_cur) + 0 * v;
`endif
    endtask

    always @(posedge clk) begin : compare
        s_note = note;
`ifdef TONEGEN_VOL_EN
        s_vol = int'(vol);
`else
        s_vol = 7;
`endif
        if (!rst_n) begin
            model_reset();
        end else begin
            // newest STABLE_CYC synchronised values equal, the one before different
            m_acc = (m_win[STABLE_CYC] != m_win[0]);
            for (int i = 1; i < STABLE_CYC; i++)
                if (m_win[i] != m_win[0]) m_acc = 1'b0;
            old_pend = m_pend;
            m_chg    = 1'b0;
            if (m_cur == 63) begin
                if (old_pend != 63) begin
                    m_cur = old_pend; m_chg = 1'b1; start_period(s_vol);
                end
            end else begin
                m_h = model_half(m_cur);
                if (m_el == 2 * m_h - 1) begin
                    if (old_pend != m_cur) begin m_cur = old_pend; m_chg = 1'b1; end
                    m_el = 0;
                    if (m_cur != 63) start_period(s_vol);
                end else if (m_el == m_h - 1 && old_pend == 63) begin
                    m_cur = 63; m_chg = 1'b1; m_el = 0;
                end else begin
                    m_el++;
                end
            end
            if (m_acc) m_pend = as_code(m_win[0]);
            for (int i = STABLE_CYC; i > 0; i--) m_win[i] = m_win[i-1];
            m_win[0] = m_s1;
            m_s1     = s_note;
        end
        #1;
        exp_v = {(m_cur != 63 && m_el < m_thr), 6'(m_cur), (m_cur != 63), m_chg};
        act_v = {buzzer, cur_note, sounding, note_chg};
        n_vec++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL cycle_check t=%0t actual{buz,cur,snd,chg}=%b expected=%b", $time, act_v, exp_v);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic wait_chg(input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!note_chg && n < maxc);
    endtask

    task automatic measure(input logic lvl, input int maxc, output int n);
        n = 0;
        while (buzzer === lvl && n < maxc) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        n_err++;
        $display("FAIL watchdog time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : stim
        int n, chg_cnt, r;
        check("model_half_24", model_half(24), 1136);
        check("model_half_27", model_half(27), 955);
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({buzzer, cur_note, sounding, note_chg}), int'({1'b0, 6'd63, 1'b0, 1'b0}));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // A4 from silence
        note = 6'd24;
        wait_chg(40, n);
        check("t1_latency", n, 7);
        check("t1_sounding", int'(sounding), 1);
        measure(1'b1, 3000, n); check("t1_high", n, 1136);
        measure(1'b0, 3000, n); check("t1_low", n, 1136);

        // change to C5 early in a high half
        note = 6'd27;
        measure(1'b1, 3000, n); check("t2_high_old", n, 1136);
        measure(1'b0, 3000, n); check("t2_low_old", n, 1136);
        check("t2_cur_note", int'(cur_note), 27);
        measure(1'b1, 3000, n); check("t2_high_new", n, 955);
        measure(1'b0, 3000, n); check("t2_low_new", n, 955);

        // unstable input must be ignored
        chg_cnt = 0;
        repeat (10) begin
            note = 6'd19;
            repeat (2) begin @(negedge clk); chg_cnt += int'(note_chg); end
            note = 6'd20;
            repeat (2) begin @(negedge clk); chg_cnt += int'(note_chg); end
        end
        note = 6'd27;
        repeat (12) begin @(negedge clk); chg_cnt += int'(note_chg); end
        check("t3_no_chg", chg_cnt, 0);
        check("t3_cur_note", int'(cur_note), 27);

        // rest code while sounding
        note = 6'd50;
        wait_chg(2500, n);
        check("t4_cur_note", int'(cur_note), 63);
        check("t4_sounding", int'(sounding), 0);
        check("t4_buzzer", int'(buzzer), 0);

        // asynchronous reset mid-tone
        note = 6'd24;
        wait_chg(40, n);
        repeat (300) @(negedge clk);
        check("t5_pre_buzzer", int'(buzzer), 1);
        #3 rst_n = 1'b0;
        #1 check("t5_async_outputs", int'({buzzer, cur_note, sounding, note_chg}), int'({1'b0, 6'd63, 1'b0, 1'b0}));
        repeat (3) @(negedge clk);
`ifdef TONEGEN_VOL_EN
        vol = 3'd3;
`endif
        rst_n = 1'b1;
        wait_chg(40, n);
        check("t5_restart_latency", n, 7);
`ifdef TONEGEN_VOL_EN
        measure(1'b1, 3000, n); check("t6_vol3_high", n, 568);
        measure(1'b0, 3000, n); check("t6_vol3_low", n, 1704);
`else
        measure(1'b1, 3000, n); check("t5_restart_high", n, 1136);
`endif

        // randomised segments checked by the compare process
        repeat (30) begin
            r = int'($urandom_range(0, 9));
`ifdef TONEGEN_VOL_EN
            vol = 3'($urandom_range(0, 7));
`endif
            if (r < 6) begin
                note = 6'($urandom_range(24, 47));
            end else if (r < 8) begin
                note = 6'($urandom_range(48, 63));
            end else begin
                repeat ($urandom_range(2, 6)) begin
                    note = 6'($urandom_range(0, 63));
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                end
                note = 6'($urandom_range(24, 47));
            end
            repeat ($urandom_range(1, 2500)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
